// File: rtl/ins_loader.sv
// ins_loader
//   Loads a program into instruction memory ahead of core execution.
//   A byte stream arrives over a valid/ready handshake; pairs of bytes
//   are assembled big-endian into 16-bit words and written to sequential
//   instruction-memory addresses starting at 0. The core is held until
//   the load completes.
//
// Ports
//   CLOCK       in   system clock (rising edge)
//   CLEAR       in   synchronous active-high reset
//   START       in   one-cycle load request, sampled only while idle
//   LEN[AW]     in   number of words to load, latched on accepted START
//   BYTE_IN[8]  in   program byte
//   BYTE_VALID  in   BYTE_IN carries a valid byte
//   BYTE_READY  out  loader accepts a byte this cycle
//   MEM_WE      out  instruction-memory write strobe
//   MEM_ADDR    out  write address
//   MEM_DATA    out  write data {high byte, low byte}
//   HOLD        out  1 = core held, 0 = core runs
//   BUSY        out  load in progress
//   DONE        out  one-cycle completion pulse
//   CHECKSUM    out  mod-2^16 sum of words written in the current load
module ins_loader #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          CLOCK,
  input  logic          CLEAR,
  input  logic          START,
  input  logic [AW-1:0] LEN,
  input  logic [7:0]    BYTE_IN,
  input  logic          BYTE_VALID,
  output logic          BYTE_READY,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_DATA,
  output logic          HOLD,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] CHECKSUM
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_HI,
    S_GET_LO,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_len, w_len;
  logic [AW-1:0] r_idx, w_idx;
  logic [7:0]    r_hi, w_hi;
  logic          r_ready, w_ready;
  logic          r_we, w_we;
  logic [AW-1:0] r_addr, w_addr;
  logic [DW-1:0] r_data, w_data;
  logic          r_hold, w_hold;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic [DW-1:0] r_csum, w_csum;

  logic          w_take;
  logic [DW-1:0] w_word;

  // r_ready is the registered handshake ready, so a byte is taken only
  // when the loader has advertised readiness for the whole cycle.
  assign w_take = r_ready & BYTE_VALID;
  assign w_word = {r_hi, BYTE_IN};

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every output is registered: the comb block computes the value each
  // output takes in the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_len       = r_len;
    w_idx       = r_idx;
    w_hi        = r_hi;
    w_ready     = 1'b0;
    w_we        = 1'b0;
    w_addr      = r_addr;
    w_data      = r_data;
    w_hold      = r_hold;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_csum      = r_csum;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_len  = LEN;
          w_idx  = '0;
          w_csum = '0;
          w_busy = 1'b1;
          w_hold = 1'b1;
          if (LEN == '0) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_GET_HI;
            w_ready     = 1'b1;
          end
        end
      end

      S_GET_HI: begin
        w_ready = 1'b1;
        if (w_take) begin
          w_hi        = BYTE_IN;
          w_state_nxt = S_GET_LO;
        end
      end

      S_GET_LO: begin
        w_ready = 1'b1;
        if (w_take) begin
          // Write strobe and checksum land together in the WRITE cycle.
          w_ready     = 1'b0;
          w_we        = 1'b1;
          w_addr      = r_idx;
          w_data      = w_word;
          w_csum      = r_csum + w_word;
          w_state_nxt = S_WRITE;
        end
      end

      S_WRITE: begin
        if (r_idx == r_len - ONE) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_idx       = r_idx + ONE;
          w_ready     = 1'b1;
          w_state_nxt = S_GET_HI;
        end
      end

      S_FINISH: begin
        // DONE, HOLD and BUSY change as the FSM returns to IDLE, so DONE
        // never overlaps the BUSY of a back-to-back reload.
        w_done      = 1'b1;
        w_hold      = 1'b0;
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_hi    <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_hold  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_csum  <= '0;
    end else begin
      r_len   <= w_len;
      r_idx   <= w_idx;
      r_hi    <= w_hi;
      r_ready <= w_ready;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_hold  <= w_hold;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_csum  <= w_csum;
    end
  end

  assign BYTE_READY = r_ready;
  assign MEM_WE     = r_we;
  assign MEM_ADDR   = r_addr;
  assign MEM_DATA   = r_data;
  assign HOLD       = r_hold;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign CHECKSUM   = r_csum;

endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader
//   Directed bench for ins_loader. Inputs are driven and outputs sampled
//   on the falling clock edge; expected values are hand-computed.
module tb_ins_loader;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          CLEAR;
  logic          START;
  logic [AW-1:0] LEN;
  logic [7:0]    BYTE_IN;
  logic          BYTE_VALID;
  logic          BYTE_READY;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_DATA;
  logic          HOLD;
  logic          BUSY;
  logic          DONE;
  logic [DW-1:0] CHECKSUM;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  ins_loader #(.AW(AW), .DW(DW)) dut (
    .CLOCK      (clk),
    .CLEAR      (CLEAR),
    .START      (START),
    .LEN        (LEN),
    .BYTE_IN    (BYTE_IN),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_DATA   (MEM_DATA),
    .HOLD       (HOLD),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .CHECKSUM   (CHECKSUM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Offer one byte and return on the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    BYTE_IN    = b;
    BYTE_VALID = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (BYTE_READY) ok = 1'b1;
      @(negedge clk);
    end
    BYTE_VALID = 1'b0;
    chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  // Return on the falling edge where DONE is high, or flag a timeout.
  task automatic wait_done(input string tag, input int limit);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (DONE) ok = 1'b1;
      else @(negedge clk);
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  // Write counter and DONE/BUSY exclusivity monitor.
  always @(negedge clk) begin
    if (MEM_WE) wr_cnt++;
    if (DONE) chk("done_busy_overlap", {31'd0, BUSY}, 32'd0);
  end

  initial begin
    CLEAR = 1'b1; START = 1'b0; LEN = '0; BYTE_IN = '0; BYTE_VALID = 1'b0;
    cyc(); cyc();
    chk("rst_hold",  {31'd0, HOLD}, 32'd1);
    chk("rst_busy",  {31'd0, BUSY}, 32'd0);
    chk("rst_done",  {31'd0, DONE}, 32'd0);
    chk("rst_we",    {31'd0, MEM_WE}, 32'd0);
    chk("rst_ready", {31'd0, BYTE_READY}, 32'd0);
    chk("rst_csum",  {16'd0, CHECKSUM}, 32'h0000);
    CLEAR = 1'b0;
    cyc();

    // Basic load, VALID held high, including a byte pending during WRITE.
    START = 1'b1; LEN = 8'd2; BYTE_VALID = 1'b1; BYTE_IN = 8'h12;
    cyc(); START = 1'b0;
    chk("b_busy",  {31'd0, BUSY}, 32'd1);
    chk("b_rdy0",  {31'd0, BYTE_READY}, 32'd1);
    chk("b_we0",   {31'd0, MEM_WE}, 32'd0);
    cyc(); BYTE_IN = 8'h34;
    cyc();
    chk("b_we1",   {31'd0, MEM_WE}, 32'd1);
    chk("b_addr1", {24'd0, MEM_ADDR}, 32'h00);
    chk("b_data1", {16'd0, MEM_DATA}, 32'h1234);
    chk("b_rdy_wr", {31'd0, BYTE_READY}, 32'd0);
    BYTE_IN = 8'hAB;
    cyc();
    chk("b_we_off", {31'd0, MEM_WE}, 32'd0);
    chk("b_rdy_hi", {31'd0, BYTE_READY}, 32'd1);
    cyc(); BYTE_IN = 8'hCD;
    cyc();
    chk("b_we2",   {31'd0, MEM_WE}, 32'd1);
    chk("b_addr2", {24'd0, MEM_ADDR}, 32'h01);
    chk("b_data2", {16'd0, MEM_DATA}, 32'hABCD);
    BYTE_VALID = 1'b0;
    cyc();
    chk("b_fin_we",   {31'd0, MEM_WE}, 32'd0);
    chk("b_fin_done", {31'd0, DONE}, 32'd0);
    chk("b_fin_hold", {31'd0, HOLD}, 32'd1);
    cyc();
    chk("b_done",  {31'd0, DONE}, 32'd1);
    chk("b_hold",  {31'd0, HOLD}, 32'd0);
    chk("b_busy0", {31'd0, BUSY}, 32'd0);
    chk("b_csum",  {16'd0, CHECKSUM}, 32'hBE01);
    chk("b_addr_hold", {24'd0, MEM_ADDR}, 32'h01);
    chk("b_data_hold", {16'd0, MEM_DATA}, 32'hABCD);
    cyc();
    chk("b_done_pulse", {31'd0, DONE}, 32'd0);
    chk("b_csum_keep",  {16'd0, CHECKSUM}, 32'hBE01);

    // Stall of three cycles between the high and low byte.
    START = 1'b1; LEN = 8'd1;
    cyc(); START = 1'b0;
    chk("s_hold_re", {31'd0, HOLD}, 32'd1);
    BYTE_IN = 8'h5A; BYTE_VALID = 1'b1;
    cyc(); BYTE_VALID = 1'b0; BYTE_IN = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s_stall_we",  {31'd0, MEM_WE}, 32'd0);
      chk("s_stall_rdy", {31'd0, BYTE_READY}, 32'd1);
    end
    BYTE_IN = 8'hC3; BYTE_VALID = 1'b1;
    cyc(); BYTE_VALID = 1'b0;
    chk("s_we",   {31'd0, MEM_WE}, 32'd1);
    chk("s_addr", {24'd0, MEM_ADDR}, 32'h00);
    chk("s_data", {16'd0, MEM_DATA}, 32'h5AC3);
    wait_done("s_done_to", 6);
    chk("s_csum", {16'd0, CHECKSUM}, 32'h5AC3);

    // LEN=0 started back-to-back in the DONE cycle.
    START = 1'b1; LEN = 8'd0;
    cyc(); START = 1'b0;
    chk("z_done0", {31'd0, DONE}, 32'd0);
    chk("z_busy",  {31'd0, BUSY}, 32'd1);
    chk("z_hold",  {31'd0, HOLD}, 32'd1);
    chk("z_csum0", {16'd0, CHECKSUM}, 32'h0000);
    cyc();
    chk("z_done",  {31'd0, DONE}, 32'd1);
    chk("z_hold0", {31'd0, HOLD}, 32'd0);
    chk("z_we",    {31'd0, MEM_WE}, 32'd0);
    chk("z_csum",  {16'd0, CHECKSUM}, 32'h0000);

    // Checksum wrap: FFFF + 0002.
    START = 1'b1; LEN = 8'd2;
    cyc(); START = 1'b0;
    chk("w_done0", {31'd0, DONE}, 32'd0);
    chk("w_busy",  {31'd0, BUSY}, 32'd1);
    send_byte(8'hFF); send_byte(8'hFF);
    chk("w_data1", {16'd0, MEM_DATA}, 32'hFFFF);
    send_byte(8'h00); send_byte(8'h02);
    chk("w_data2", {16'd0, MEM_DATA}, 32'h0002);
    wait_done("w_done_to", 6);
    chk("w_csum", {16'd0, CHECKSUM}, 32'h0001);
    cyc();

    // START while busy must not relatch LEN.
    START = 1'b1; LEN = 8'd1;
    cyc(); START = 1'b0;
    START = 1'b1; LEN = 8'd3;
    cyc(); START = 1'b0;
    chk("i_busy", {31'd0, BUSY}, 32'd1);
    send_byte(8'hAA); send_byte(8'h55);
    chk("i_we",   {31'd0, MEM_WE}, 32'd1);
    chk("i_addr", {24'd0, MEM_ADDR}, 32'h00);
    chk("i_data", {16'd0, MEM_DATA}, 32'hAA55);
    wait_done("i_done_to", 4);
    chk("i_csum", {16'd0, CHECKSUM}, 32'hAA55);
    cyc();

    // Abort in GET_LO after word 0 was written; START with CLEAR ignored.
    START = 1'b1; LEN = 8'd3;
    cyc(); START = 1'b0;
    send_byte(8'h11); send_byte(8'h22);
    chk("a_data0", {16'd0, MEM_DATA}, 32'h1122);
    cyc();
    send_byte(8'h33);
    CLEAR = 1'b1; START = 1'b1; LEN = 8'd5;
    cyc(); CLEAR = 1'b0; START = 1'b0;
    chk("a_hold", {31'd0, HOLD}, 32'd1);
    chk("a_busy", {31'd0, BUSY}, 32'd0);
    chk("a_we",   {31'd0, MEM_WE}, 32'd0);
    chk("a_rdy",  {31'd0, BYTE_READY}, 32'd0);
    BYTE_IN = 8'h44; BYTE_VALID = 1'b1;
    cyc(); cyc();
    chk("a_idle_we",   {31'd0, MEM_WE}, 32'd0);
    chk("a_idle_rdy",  {31'd0, BYTE_READY}, 32'd0);
    chk("a_idle_busy", {31'd0, BUSY}, 32'd0);
    BYTE_VALID = 1'b0;
    cyc();

    chk("write_count", wr_cnt, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
